block_1_apb_initiator: RTL and testbench

//  APB initiator driving register accesses into block_1 (7-bit byte address space, 32-bit registers).

---
 rtl/block_1_apb_initiator.sv | 178 +++++++++++++++++
 tb/tb_block_1_apb_initiator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_1_apb_initiator.sv
// APB initiator for block_1: one command in, one APB setup/access transfer out, one response back.
// Optional feature macro: BLOCK_1_APB_INITIATOR_ADDR_CHECK_EN (address decode check in IDLE).
module block_1_apb_initiator #(
    parameter int ADDRESS_WIDTH  = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]     i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_strb,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]                o_rsp_status,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic [ADDRESS_WIDTH-1:0]  o_paddr,
    output logic [2:0]                o_pprot,
    output logic                      o_pwrite,
    output logic [DATA_WIDTH-1:0]     o_pwdata,
    output logic [DATA_WIDTH/8-1:0]   o_pstrb,
    input  logic                      i_pready,
    input  logic [DATA_WIDTH-1:0]     i_prdata,
    input  logic                      i_pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_DECERR  = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
    logic                       pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [STRB_W-1:0]          pstrb_q, pstrb_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                 rsp_status_q, rsp_status_d;
    logic                       addr_bad;

`ifdef BLOCK_1_APB_INITIATOR_ADDR_CHECK_EN
    // Misaligned or beyond the last implemented block_1 register.
    assign addr_bad = (i_cmd_addr[1:0] != 2'b00) || (i_cmd_addr >= ADDRESS_WIDTH'(88));
`else
    assign addr_bad = 1'b0;
`endif

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = cmd_ready_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    paddr_d     = i_cmd_addr;
                    pwrite_d    = i_cmd_write;
                    pwdata_d    = i_cmd_wdata;
                    pstrb_d     = i_cmd_write ? i_cmd_strb : '0;
                    if (addr_bad) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_DECERR;
                        rsp_rdata_d  = '0;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Completion is checked before the limit so a late pready still wins.
                if (i_pready) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = i_pslverr ? ST_SLVERR : ST_OK;
                    rsp_rdata_d  = (i_pslverr || pwrite_q) ? '0 : i_prdata;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIM)) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_rdata_d  = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_psel       = psel_q;
    assign o_penable    = penable_q;
    assign o_paddr      = paddr_q;
    assign o_pprot      = 3'b000;
    assign o_pwrite     = pwrite_q;
    assign o_pwdata     = pwdata_q;
    assign o_pstrb      = pstrb_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_block_1_apb_initiator.sv
// Randomized and directed bench for block_1_apb_initiator against a transaction-level model;
// a second instance with TIMEOUT_CYCLES=0 covers the disabled-timeout case.
`timescale 1ns/1ps
module tb_block_1_apb_initiator;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_write, rsp_ready, pready, pslverr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, prdata;
    logic [SW-1:0] cmd_strb;
    bit            sel_z;

    logic          a_cmd_ready, a_rsp_valid, a_psel, a_penable, a_pwrite;
    logic [DW-1:0] a_rsp_rdata, a_pwdata;
    logic [1:0]    a_rsp_status;
    logic [AW-1:0] a_paddr;
    logic [2:0]    a_pprot;
    logic [SW-1:0] a_pstrb;
    logic          z_cmd_ready, z_rsp_valid, z_psel, z_penable, z_pwrite;
    logic [DW-1:0] z_rsp_rdata, z_pwdata;
    logic [1:0]    z_rsp_status;
    logic [AW-1:0] z_paddr;
    logic [2:0]    z_pprot;
    logic [SW-1:0] z_pstrb;

    logic          m_cmd_ready, m_rsp_valid, m_psel, m_penable, m_pwrite;
    logic [DW-1:0] m_rsp_rdata, m_pwdata;
    logic [1:0]    m_rsp_status;
    logic [AW-1:0] m_paddr;
    logic [2:0]    m_pprot;
    logic [SW-1:0] m_pstrb;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    block_1_apb_initiator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid && !sel_z), .o_cmd_ready(a_cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_strb(cmd_strb),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready && !sel_z),
        .o_rsp_rdata(a_rsp_rdata), .o_rsp_status(a_rsp_status),
        .o_psel(a_psel), .o_penable(a_penable), .o_paddr(a_paddr), .o_pprot(a_pprot),
        .o_pwrite(a_pwrite), .o_pwdata(a_pwdata), .o_pstrb(a_pstrb),
        .i_pready(pready && !sel_z), .i_prdata(prdata), .i_pslverr(pslverr)
    );

    block_1_apb_initiator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) u_dut_z (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid && sel_z), .o_cmd_ready(z_cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_strb(cmd_strb),
        .o_rsp_valid(z_rsp_valid), .i_rsp_ready(rsp_ready && sel_z),
        .o_rsp_rdata(z_rsp_rdata), .o_rsp_status(z_rsp_status),
        .o_psel(z_psel), .o_penable(z_penable), .o_paddr(z_paddr), .o_pprot(z_pprot),
        .o_pwrite(z_pwrite), .o_pwdata(z_pwdata), .o_pstrb(z_pstrb),
        .i_pready(pready && sel_z), .i_prdata(prdata), .i_pslverr(pslverr)
    );

    assign m_cmd_ready  = sel_z ? z_cmd_ready  : a_cmd_ready;
    assign m_rsp_valid  = sel_z ? z_rsp_valid  : a_rsp_valid;
    assign m_rsp_rdata  = sel_z ? z_rsp_rdata  : a_rsp_rdata;
    assign m_rsp_status = sel_z ? z_rsp_status : a_rsp_status;
    assign m_psel       = sel_z ? z_psel       : a_psel;
    assign m_penable    = sel_z ? z_penable    : a_penable;
    assign m_paddr      = sel_z ? z_paddr      : a_paddr;
    assign m_pprot      = sel_z ? z_pprot      : a_pprot;
    assign m_pwrite     = sel_z ? z_pwrite     : a_pwrite;
    assign m_pwdata     = sel_z ? z_pwdata     : a_pwdata;
    assign m_pstrb      = sel_z ? z_pstrb      : a_pstrb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit decode_err(input logic [AW-1:0] a);
`ifdef BLOCK_1_APB_INITIATOR_ADDR_CHECK_EN
        return (a % 4 != 0) || (a >= 88);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(m_cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(m_rsp_valid), 0);
        chk({tag, "_rdata"},     m_rsp_rdata, 0);
        chk({tag, "_status"},    32'(m_rsp_status), 0);
        chk({tag, "_psel"},      32'(m_psel), 0);
        chk({tag, "_penable"},   32'(m_penable), 0);
        chk({tag, "_paddr"},     32'(m_paddr), 0);
        chk({tag, "_pprot"},     32'(m_pprot), 0);
        chk({tag, "_pwrite"},    32'(m_pwrite), 0);
        chk({tag, "_pwdata"},    m_pwdata, 0);
        chk({tag, "_pstrb"},     32'(m_pstrb), 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] st, input int waits, input bit err,
                           input logic [DW-1:0] rd, input int hold);
        int         lim, rsp_c, n;
        bit         dec;
        logic [1:0] exp_st;
        logic [DW-1:0] exp_rd;
        lim = sel_z ? 0 : TO;
        dec = decode_err(addr);
        if (dec) begin
            rsp_c = 1; exp_st = 2'b11; exp_rd = '0;
        end else if (lim != 0 && waits >= lim) begin
            rsp_c = 2 + lim; exp_st = 2'b10; exp_rd = '0;
        end else begin
            rsp_c = 3 + waits; exp_st = err ? 2'b01 : 2'b00; exp_rd = (err || wr) ? '0 : rd;
        end

        n = 0;
        while (!m_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_idle", 32'(m_cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        pslverr = err; prdata = rd;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c < rsp_c; c++) begin
            chk("bus_psel",      32'(m_psel), 1);
            chk("bus_penable",   32'(m_penable), (c >= 2) ? 1 : 0);
            chk("bus_paddr",     32'(m_paddr), 32'(addr));
            chk("bus_pwrite",    32'(m_pwrite), 32'(wr));
            chk("bus_pstrb",     32'(m_pstrb), wr ? 32'(st) : 0);
            if (wr) chk("bus_pwdata", m_pwdata, wd);
            chk("bus_cmd_ready", 32'(m_cmd_ready), 0);
            chk("bus_rsp_valid", 32'(m_rsp_valid), 0);
            pready = (c == 2 + waits);
            @(negedge clk);
        end
        pready = 1'b0;
        chk("rsp_valid",  32'(m_rsp_valid), 1);
        chk("rsp_status", 32'(m_rsp_status), 32'(exp_st));
        chk("rsp_rdata",  m_rsp_rdata, exp_rd);
        chk("rsp_psel",   32'(m_psel), 0);
        chk("rsp_penable", 32'(m_penable), 0);
        chk("rsp_cmd_ready", 32'(m_cmd_ready), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid",     32'(m_rsp_valid), 1);
            chk("hold_status",    32'(m_rsp_status), 32'(exp_st));
            chk("hold_rdata",     m_rsp_rdata, exp_rd);
            chk("hold_cmd_ready", 32'(m_cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid",     32'(m_rsp_valid), 0);
        chk("done_cmd_ready", 32'(m_cmd_ready), 1);
        chk("done_psel",      32'(m_psel), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0; sel_z = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 7'h04, 32'h0000_00a5, 4'hf, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 7'h20, 32'h0, 4'hf, 3, 1'b0, 32'h0000_0c3a, 0);
        run_txn(1'b0, 7'h10, 32'h0, 4'h0, 0, 1'b1, 32'hdead_beef, 0);
        run_txn(1'b0, 7'h0c, 32'h0, 4'h0, TO - 1, 1'b0, 32'h1234_5678, 1);
        run_txn(1'b0, 7'h0c, 32'h0, 4'h0, TO, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b1, 7'h18, 32'hcafe_f00d, 4'h5, 40, 1'b0, 32'h0, 0);
        run_txn(1'b1, 7'h08, 32'h0bad_0bad, 4'h3, 1, 1'b0, 32'h0, 5);
        run_txn(1'b0, 7'h06, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0066, 0);
        run_txn(1'b0, 7'h58, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0058, 0);

        sel_z = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 7'h08, 32'h0, 4'h0, 30, 1'b0, 32'h7777_0001, 0);
        sel_z = 1'b0;
        @(negedge clk);

        // Reset while the transfer sits in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h14; cmd_wdata = 32'hffff_ffff; cmd_strb = 4'hf;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!m_penable && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_penable", 32'(m_penable), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_rsp", 32'(m_rsp_valid), 0);
            chk("post_reset_no_psel", 32'(m_psel), 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), a, $urandom, SW'($urandom_range(0, 15)),
                    int'($urandom_range(0, TO + 2)), ($urandom_range(0, 3) == 0),
                    $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
